// File: rtl/salvo_sequencer.sv
// salvo_sequencer: turns an operator salvo request into spaced single-cycle
// fire pulses for the rocket pod, confirms every shot against the pod's
// reported rocket count, inserts a reload when the pod reaches reserve and
// abandons the salvo on loss of radar lock or master arm.
module salvo_sequencer #(
    parameter int unsigned SALVO_MAX       = 8,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned CONFIRM_TIMEOUT = 8,
    parameter int unsigned FULL_LOAD       = 24,
    parameter int unsigned RESERVE         = 1,
    parameter int unsigned RELOAD_TIMEOUT  = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic [3:0] salvo_size,
    input  logic       radar,
    input  logic       armed,
    input  logic [4:0] rockets,
    input  logic       fault_clr,
    output logic       fire,
    output logic       reload,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       fault,
    output logic [3:0] fired_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRE    = 3'd1,
        CONFIRM = 3'd2,
        GAP     = 3'd3,
        RELOAD  = 3'd4,
        RLWAIT  = 3'd5,
        FAULT   = 3'd6
    } state_t;

    // One shared wait counter serves GAP, CONFIRM and RLWAIT; size it for the longest wait.
    localparam int unsigned CNT_MAX_A = (GAP_CYCLES > CONFIRM_TIMEOUT) ? GAP_CYCLES : CONFIRM_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RELOAD_TIMEOUT) ? CNT_MAX_A : RELOAD_TIMEOUT;
    localparam int          CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELOAD_LAST  = CNT_W'(RELOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [4:0] FULL_L      = 5'(FULL_LOAD);
    localparam logic [4:0] RESERVE_L   = 5'(RESERVE);
    localparam logic [3:0] SALVO_MAX_L = 4'(SALVO_MAX);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       remaining, remaining_next;
    logic [4:0]       snapshot, snapshot_next;
    logic [3:0]       count_next;
    logic             fire_next, reload_next, busy_next, done_next, aborted_next, fault_next;
    logic [3:0]       clipped;
    logic             abort_req;
    logic             in_salvo;

    // State, salvo bookkeeping and every output are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            remaining   <= '0;
            snapshot    <= '0;
            fired_count <= '0;
            fire        <= 1'b0;
            reload      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_next;
            cnt         <= cnt_next;
            remaining   <= remaining_next;
            snapshot    <= snapshot_next;
            fired_count <= count_next;
            fire        <= fire_next;
            reload      <= reload_next;
            busy        <= busy_next;
            done        <= done_next;
            aborted     <= aborted_next;
            fault       <= fault_next;
        end
    end

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next     = state;
        cnt_next       = '0;
        remaining_next = remaining;
        snapshot_next  = snapshot;
        count_next     = fired_count;
        done_next      = 1'b0;
        aborted_next   = 1'b0;
        clipped        = (salvo_size > SALVO_MAX_L) ? SALVO_MAX_L : salvo_size;
        abort_req      = !radar || !armed;
        in_salvo       = (state != IDLE) && (state != FAULT);

        if (in_salvo && abort_req) begin
            // Loss of lock or arm overrides everything while a salvo is in flight.
            state_next   = IDLE;
            aborted_next = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger && radar && armed && (salvo_size != 4'd0)) begin
                        remaining_next = clipped;
                        count_next     = '0;
                        state_next     = (rockets <= RESERVE_L) ? RELOAD : FIRE;
                    end
                end
                FIRE: begin
                    // Pod count before this shot lands; the pod updates on this edge.
                    snapshot_next = rockets;
                    state_next    = CONFIRM;
                end
                CONFIRM: begin
                    if (rockets == snapshot - 5'd1) begin
                        count_next     = fired_count + 4'd1;
                        remaining_next = remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = GAP;
                        end
                    end else if (cnt == CONFIRM_LAST) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_next = (rockets <= RESERVE_L) ? RELOAD : FIRE;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                RELOAD: begin
                    state_next = RLWAIT;
                end
                RLWAIT: begin
                    if (rockets == FULL_L) begin
                        state_next = FIRE;
                    end else if (cnt == RELOAD_LAST) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // FIRE and RELOAD last exactly one cycle and are never adjacent, so the
        // pulses inherit those guarantees from the state sequence.
        fire_next   = (state_next == FIRE);
        reload_next = (state_next == RELOAD);
        busy_next   = (state_next != IDLE) && (state_next != FAULT);
        fault_next  = (state_next == FAULT);
    end

endmodule
